// File: rtl/router_pkt_tx.sv
// router_pkt_tx: source-side packet transmitter for the router input port.
// A 64x8 payload buffer is loaded while idle, then a start pulse sends
// header {len,addr}, len payload bytes and a parity byte, honouring busy.
// After the parity byte the router err flag is watched for ERR_WAIT cycles
// and the result is reported with a one-cycle done pulse.
// Optional feature: define ROUTER_TX_PARITY_INJ_EN to add the inject_err
// input, which corrupts bit 0 of the transmitted parity byte.
module router_pkt_tx #(
    parameter int ERR_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             wr_en,
    input  logic [5:0]       wr_addr,
    input  logic [7:0]       wr_data,
    input  logic             start,
    input  logic [1:0]       addr,
    input  logic [5:0]       len,
`ifdef ROUTER_TX_PARITY_INJ_EN
    input  logic             inject_err,
`endif
    input  logic             busy,
    input  logic             err,
    output logic             pkt_valid,
    output logic [7:0]       data_in,
    output logic             tx_active,
    output logic             done,
    output logic             err_seen,
    output logic             cfg_err,
    output logic [CNT_W-1:0] pkt_count
);

    localparam int WAIT_W = $clog2(ERR_WAIT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_PAR,
        ST_ERRW
    } state_t;

    state_t state_q, state_d;

    logic [7:0]        mem [64];

    // Datapath registers (not reset: always loaded before use)
    logic [5:0]        len_q, len_d;
    logic [5:0]        idx_q, idx_d;
    logic [7:0]        par_q, par_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic [7:0]        par_flip;

    // Next values of the registered outputs
    logic              pkt_valid_d;
    logic [7:0]        data_d;
    logic              tx_active_d;
    logic              done_d;
    logic              err_seen_d;
    logic              cfg_err_d;
    logic [CNT_W-1:0]  count_d;

`ifdef ROUTER_TX_PARITY_INJ_EN
    logic              inj_q, inj_d;
    assign par_flip = {7'b0, inj_q};
`else
    assign par_flip = 8'h00;
`endif

    // Payload buffer: loadable only while idle so a packet in flight is stable
    always_ff @(posedge clock) begin
        if (wr_en && state_q == ST_IDLE) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Next-state and next-output logic; outputs hold by default (busy hold)
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        par_d       = par_q;
        cnt_d       = cnt_q;
`ifdef ROUTER_TX_PARITY_INJ_EN
        inj_d       = inj_q;
`endif
        pkt_valid_d = pkt_valid;
        data_d      = data_in;
        tx_active_d = tx_active;
        done_d      = 1'b0;
        err_seen_d  = err_seen;
        cfg_err_d   = 1'b0;
        count_d     = pkt_count;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != 6'd0 && addr != 2'd3) begin
                        state_d     = ST_HDR;
                        len_d       = len;
                        par_d       = {len, addr};
                        data_d      = {len, addr};
                        pkt_valid_d = 1'b1;
                        tx_active_d = 1'b1;
                        err_seen_d  = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
                        inj_d       = inject_err;
`endif
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_HDR: begin
                // par already holds the header, so only payload is folded in later
                if (!busy) begin
                    data_d  = mem[6'd0];
                    idx_d   = 6'd1;
                    state_d = ST_PAY;
                end
            end
            ST_PAY: begin
                // data_in is the payload byte being accepted on this edge
                if (!busy) begin
                    par_d = par_q ^ data_in;
                    if (idx_q < len_q) begin
                        data_d = mem[idx_q];
                        idx_d  = idx_q + 6'd1;
                    end else begin
                        data_d      = par_q ^ data_in ^ par_flip;
                        pkt_valid_d = 1'b0;
                        state_d     = ST_PAR;
                    end
                end
            end
            ST_PAR: begin
                if (!busy) begin
                    data_d  = 8'h00;
                    cnt_d   = WAIT_W'(ERR_WAIT);
                    state_d = ST_ERRW;
                end
            end
            ST_ERRW: begin
                err_seen_d = err_seen | err;
                if (cnt_q == WAIT_W'(1)) begin
                    done_d      = 1'b1;
                    tx_active_d = 1'b0;
                    count_d     = pkt_count + CNT_W'(1);
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control state and registered outputs, cleared by synchronous reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            pkt_valid <= 1'b0;
            data_in   <= 8'h00;
            tx_active <= 1'b0;
            done      <= 1'b0;
            err_seen  <= 1'b0;
            cfg_err   <= 1'b0;
            pkt_count <= '0;
        end else begin
            state_q   <= state_d;
            pkt_valid <= pkt_valid_d;
            data_in   <= data_d;
            tx_active <= tx_active_d;
            done      <= done_d;
            err_seen  <= err_seen_d;
            cfg_err   <= cfg_err_d;
            pkt_count <= count_d;
        end
    end

    // Packet datapath registers
    always_ff @(posedge clock) begin
        len_q <= len_d;
        idx_q <= idx_d;
        par_q <= par_d;
        cnt_q <= cnt_d;
`ifdef ROUTER_TX_PARITY_INJ_EN
        inj_q <= inj_d;
`endif
    end

endmodule
